rggen_bus_arbiter: RTL

RGGEN_BUS_ARBITER -- requirements
Module: rggen_bus_arbiter

---
 rtl/rggen_bus_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter that funnels several host-side register requesters onto a
// single bus-splitter port, one outstanding access at a time, with a timeout.
module rggen_bus_arbiter #(
  parameter int REQUESTERS     = 2,
  parameter int ADDRESS_WIDTH  = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQUESTERS-1:0]            i_req,
  input  logic [REQUESTERS-1:0]            i_write,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_address,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] i_write_data,
  output logic [REQUESTERS-1:0]            o_ack,
  output logic [1:0]                       o_status,
  output logic [DATA_WIDTH-1:0]            o_read_data,
  output logic                             o_bus_request,
  output logic                             o_bus_write,
  output logic [ADDRESS_WIDTH-1:0]         o_bus_address,
  output logic [DATA_WIDTH-1:0]            o_bus_write_data,
  input  logic                             i_bus_done,
  input  logic                             i_bus_error,
  input  logic [DATA_WIDTH-1:0]            i_bus_read_data
);

  localparam int GW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_e;

  state_e                  state;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           next_grant;
  logic                    grant_valid;
  logic [CW-1:0]           busy_count;
  logic [REQUESTERS-1:0]   grant_onehot;
  logic                    sel_write;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [DATA_WIDTH-1:0]   sel_write_data;
  int                      best_dist;

  // Pick the requester closest (in rotation order) to last_grant+1.
  always_comb begin
    next_grant  = last_grant;
    grant_valid = 1'b0;
    best_dist   = REQUESTERS;
    for (int j = 0; j < REQUESTERS; j++) begin
      if (i_req[j] && (((j + REQUESTERS - 1 - int'(last_grant)) % REQUESTERS) < best_dist)) begin
        best_dist   = (j + REQUESTERS - 1 - int'(last_grant)) % REQUESTERS;
        next_grant  = GW'(j);
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_write      = 1'b0;
    sel_address    = '0;
    sel_write_data = '0;
    grant_onehot   = '0;
    for (int j = 0; j < REQUESTERS; j++) begin
      if (next_grant == GW'(j)) begin
        sel_write      = i_write[j];
        sel_address    = i_address[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_write_data = i_write_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
      grant_onehot[j] = (grant == GW'(j));
    end
  end

  // Command registers stay frozen from grant until the access completes,
  // so requester-side changes during BUSY/ACK cannot leak into the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      grant            <= '0;
      last_grant       <= GW'(REQUESTERS - 1);
      busy_count       <= '0;
      o_ack            <= '0;
      o_status         <= 2'b00;
      o_read_data      <= '0;
      o_bus_request    <= 1'b0;
      o_bus_write      <= 1'b0;
      o_bus_address    <= '0;
      o_bus_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            grant            <= next_grant;
            last_grant       <= next_grant;
            o_bus_write      <= sel_write;
            o_bus_address    <= sel_address;
            o_bus_write_data <= sel_write_data;
            busy_count       <= '0;
            o_bus_request    <= 1'b1;
            state            <= BUSY;
          end
        end
        BUSY: begin
          if (i_bus_done) begin
            o_bus_request <= 1'b0;
            o_ack         <= grant_onehot;
            o_status      <= i_bus_error ? 2'b01 : 2'b00;
            o_read_data   <= o_bus_write ? '0 : i_bus_read_data;
            state         <= ACK;
          end else if (busy_count == CW'(TIMEOUT_CYCLES - 1)) begin
            o_bus_request <= 1'b0;
            o_ack         <= grant_onehot;
            o_status      <= 2'b10;
            o_read_data   <= '0;
            state         <= ACK;
          end else begin
            busy_count <= busy_count + CW'(1);
          end
        end
        ACK: begin
          o_ack       <= '0;
          o_status    <= 2'b00;
          o_read_data <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
